// File: rtl/ps2_rx_core_if.sv
// -----------------------------------------------------------------------------
// ps2_rx_core_if
//
// Parallel-side bundle of the PS/2 receiver. It carries the receive enable
// and the byte output with its completion strobe. The PS/2 pins are not part
// of this bundle and stay as plain ports on the core.
//
// Signals:
//   rx_en        : receive enable, driven by the protocol logic
//   dout[7:0]    : last correctly received data byte
//   rx_done_tick : one-cycle pulse when dout is updated
//
// Modports:
//   master : protocol-logic side (drives rx_en, observes dout/rx_done_tick)
//   slave  : receiver-core side (observes rx_en, drives dout/rx_done_tick)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

interface ps2_rx_core_if;
  logic       rx_en;
  logic [7:0] dout;
  logic       rx_done_tick;

  modport master (
    output rx_en,
    input  dout,
    input  rx_done_tick
  );

  modport slave (
    input  rx_en,
    output dout,
    output rx_done_tick
  );
endinterface

// File: rtl/ps2_rx_core.sv
// -----------------------------------------------------------------------------
// ps2_rx_core
//
// PS/2 device-to-host serial receiver. It deserialises 11-bit frames
// (start, 8 data bits LSB first, odd parity, stop) sampled on the falling
// edges of a debounced PS/2 clock. Each completed frame is presented as a
// byte on dout together with a one-cycle rx_done_tick. The PS/2 lines are
// only ever sampled; this block never drives them.
//
// Parameters:
//   FILTER_LEN     : consecutive identical clk samples needed before the
//                    filtered PS/2 clock may change level
//   TIMEOUT_CYCLES : idle clk cycles inside a frame after which the frame
//                    is abandoned
//
// Ports:
//   clk   : system clock
//   reset : asynchronous active-low reset
//   ps2c  : PS/2 clock line (sampled only)
//   ps2d  : PS/2 data line (sampled only)
//   bus   : ps2_rx_core_if.slave (rx_en in, dout / rx_done_tick out)
//
// Build option:
//   PS2_RX_PARITY_CHECK_EN : when defined, a frame is only accepted with a
//                            stop bit of 1 and odd parity over data+parity.
//                            When undefined, every completed frame is
//                            accepted.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module ps2_rx_core #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic          clk,
  input  logic          reset,
  inout  wire           ps2c,
  inout  wire           ps2d,
  ps2_rx_core_if.slave  bus
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DPS  = 2'd1,
    ST_LOAD = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchronisers. Both lines idle high, so they reset to 1 to avoid a
  // spurious falling edge when reset is released.
  // ---------------------------------------------------------------------------
  logic ps2c_meta_q, ps2c_sync_q;
  logic ps2d_meta_q, ps2d_sync_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ps2c_meta_q <= 1'b1;
      ps2c_sync_q <= 1'b1;
      ps2d_meta_q <= 1'b1;
      ps2d_sync_q <= 1'b1;
    end else begin
      ps2c_meta_q <= ps2c;
      ps2c_sync_q <= ps2c_meta_q;
      ps2d_meta_q <= ps2d;
      ps2d_sync_q <= ps2d_meta_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Clock filter: the filtered level only changes once the whole sample
  // window agrees, so pulses shorter than FILTER_LEN cycles are swallowed.
  // The level is decided on the window contents being loaded this cycle so
  // that the edge pulse and the new level appear together.
  // ---------------------------------------------------------------------------
  logic [FILTER_LEN-1:0] filter_q, filter_d;
  logic                  f_level_q, f_level_d;
  logic                  fall_edge_q, fall_edge_d;

  always_comb begin
    filter_d = {ps2c_sync_q, filter_q[FILTER_LEN-1:1]};
    if (&filter_d) begin
      f_level_d = 1'b1;
    end else if (~|filter_d) begin
      f_level_d = 1'b0;
    end else begin
      f_level_d = f_level_q;
    end
    fall_edge_d = f_level_q & ~f_level_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      filter_q    <= '1;
      f_level_q   <= 1'b1;
      fall_edge_q <= 1'b0;
    end else begin
      filter_q    <= filter_d;
      f_level_q   <= f_level_d;
      fall_edge_q <= fall_edge_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame FSM state.
  // ---------------------------------------------------------------------------
  state_t          state_q, state_d;
  logic [10:0]     b_q, b_d;
  logic [3:0]      n_q, n_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [7:0]      dout_q, dout_d;
  logic            tick_q, tick_d;

  // Frame register after shifting in the current data sample.
  logic [10:0] shift_b;
  logic        frame_ok;

  assign shift_b = {ps2d_sync_q, b_q[10:1]};

`ifdef PS2_RX_PARITY_CHECK_EN
  // Stop bit must be 1 and data+parity must hold an odd number of ones.
  assign frame_ok = shift_b[10] & (^shift_b[9:1]);
`else
  assign frame_ok = 1'b1;
`endif

  // The frame is judged on the transition into LOAD so that dout and the
  // registered tick are both valid during the single LOAD cycle.
  always_comb begin
    state_d = state_q;
    b_d     = b_q;
    n_d     = n_q;
    timer_d = timer_q;
    dout_d  = dout_q;
    tick_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        // Only a low data line on the edge is a genuine start bit.
        if (fall_edge_q && bus.rx_en && !ps2d_sync_q) begin
          b_d     = shift_b;
          n_d     = 4'd9;
          state_d = ST_DPS;
        end
      end

      ST_DPS: begin
        if (fall_edge_q) begin
          b_d     = shift_b;
          timer_d = '0;
          if (n_q == 4'd0) begin
            state_d = ST_LOAD;
            if (frame_ok) begin
              dout_d = shift_b[8:1];
              tick_d = 1'b1;
            end
          end else begin
            n_d = n_q - 4'd1;
          end
        end else if (timer_q == TIMER_LAST) begin
          // Device stopped clocking mid-frame: drop the partial frame.
          state_d = ST_IDLE;
          timer_d = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      ST_LOAD: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      b_q     <= '0;
      n_q     <= '0;
      timer_q <= '0;
      dout_q  <= 8'h00;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      b_q     <= b_d;
      n_q     <= n_d;
      timer_q <= timer_d;
      dout_q  <= dout_d;
      tick_q  <= tick_d;
    end
  end

  assign bus.dout         = dout_q;
  assign bus.rx_done_tick = tick_q;

endmodule

// File: tb/tb_ps2_rx_core.sv
// -----------------------------------------------------------------------------
// tb_ps2_rx_core
//
// Self-checking bench for ps2_rx_core. Frames are generated on the PS/2 pins
// with a 40 us PS/2 clock (200 system clocks at a 5 MHz bench clock). A
// reference model decides from the frame contents and rx_en whether a byte
// is expected; expected bytes go into a queue that an independent monitor
// pops each time rx_done_tick is seen.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_ps2_rx_core;

  localparam int FILTER_LEN     = 8;
  localparam int TIMEOUT_CYCLES = 2000;
  localparam int HALF           = 100;   // half PS/2 period in clk cycles

  logic clk       = 1'b0;
  logic reset     = 1'b0;
  logic ps2c_drv  = 1'b1;
  logic ps2d_drv  = 1'b1;
  wire  ps2c_w;
  wire  ps2d_w;

  assign ps2c_w = ps2c_drv;
  assign ps2d_w = ps2d_drv;

  ps2_rx_core_if bus ();

  ps2_rx_core #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .ps2c (ps2c_w),
    .ps2d (ps2d_w),
    .bus  (bus)
  );

  always #100 clk = ~clk;

  // Scoreboard state
  logic [7:0] exp_q[$];
  logic [7:0] model_dout = 8'h00;
  int         n_cmp      = 0;
  int         n_err      = 0;
  int         tick_cnt   = 0;

  // ---------------------------------------------------------------------------
  // Reference model: a frame yields a byte if the receiver was enabled at the
  // start bit, and (with parity checking) the stop bit is 1 and the total
  // number of ones in data plus parity is odd.
  // ---------------------------------------------------------------------------
  function automatic bit model_accept(input logic [7:0] d, input logic par,
                                      input logic stop, input logic en);
    int ones;
    ones = $countones(d) + int'(par);
`ifdef PS2_RX_PARITY_CHECK_EN
    return en && stop && ((ones % 2) == 1);
`else
    return en;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: every tick must match the next expected byte.
  always @(negedge clk) begin
    if (bus.rx_done_tick === 1'b1) begin
      logic [7:0] e;
      tick_cnt++;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_tick: got dout=%02h expected no tick", bus.dout);
      end else begin
        e = exp_q.pop_front();
        if (bus.dout !== e) begin
          n_err++;
          $display("FAIL tick_dout: got %02h expected %02h", bus.dout, e);
        end else begin
          $display("tick dout=%02h", bus.dout);
        end
      end
    end
  end

  // Drive nbits of a frame. glitch_bit: bit during whose high phase a
  // 3-cycle low pulse is put on ps2c (-1 = none). drop_en_bit: bit after
  // which rx_en is lowered (-1 = never).
  task automatic send_bits(input logic [7:0] d, input logic par, input logic stop,
                           input int nbits, input int glitch_bit, input int drop_en_bit);
    logic bit_v;
    for (int i = 0; i < nbits; i++) begin
      if (i == 0)      bit_v = 1'b0;
      else if (i <= 8) bit_v = d[i-1];
      else if (i == 9) bit_v = par;
      else             bit_v = stop;
      ps2d_drv = bit_v;
      if (i == glitch_bit) begin
        repeat (20) @(posedge clk);
        ps2c_drv = 1'b0;
        repeat (3) @(posedge clk);
        ps2c_drv = 1'b1;
        repeat (27) @(posedge clk);
      end else begin
        repeat (50) @(posedge clk);
      end
      ps2c_drv = 1'b0;
      repeat (HALF) @(posedge clk);
      ps2c_drv = 1'b1;
      repeat (50) @(posedge clk);
      if (i == drop_en_bit) bus.rx_en = 1'b0;
    end
    ps2d_drv = 1'b1;
  endtask

  // Full frame transaction with model prediction and post-frame checks.
  task automatic issue(input string name, input logic [7:0] d, input logic par,
                       input logic stop, input int glitch_bit, input int drop_en_bit);
    bit acc;
    int t0;
    acc = model_accept(d, par, stop, bus.rx_en);
    if (acc) begin
      exp_q.push_back(d);
      model_dout = d;
    end
    $display("frame %s data=%02h par=%0b stop=%0b en=%0b expect_tick=%0b",
             name, d, par, stop, bus.rx_en, acc);
    t0 = tick_cnt;
    send_bits(d, par, stop, 11, glitch_bit, drop_en_bit);
    repeat (20) @(posedge clk);
    #1;
    check({name, "_ticks"}, 32'(tick_cnt - t0), acc ? 32'd1 : 32'd0);
    check({name, "_dout"}, {24'h0, bus.dout}, {24'h0, model_dout});
  endtask

  // Watchdog
  initial begin
    repeat (150000) @(posedge clk);
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [7:0] rd;
    logic       rpar, rstop;
    int         drop;

    bus.rx_en = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("reset_dout", {24'h0, bus.dout}, 32'h0);
    check("reset_tick", {31'h0, bus.rx_done_tick}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    repeat (20) @(posedge clk);

    // 1: good frame
    issue("t1_a5", 8'hA5, 1'b1, 1'b1, -1, -1);

    // 2: disabled, then enabled
    bus.rx_en = 1'b0;
    issue("t2_dis", 8'h12, 1'b1, 1'b1, -1, -1);
    bus.rx_en = 1'b1;
    issue("t2_en", 8'h12, 1'b1, 1'b1, -1, -1);

    // 3: bad parity
    issue("t3_badpar", 8'h3C, 1'b0, 1'b1, -1, -1);

    // 4: glitch while idle, then glitch mid-frame
    ps2c_drv = 1'b0;
    repeat (3) @(posedge clk);
    ps2c_drv = 1'b1;
    repeat (50) @(posedge clk);
    issue("t4_glitch", 8'h81, 1'b1, 1'b1, 4, -1);

    // 5: truncated frame, timeout, then full frame
    $display("frame t5_partial bits=5");
    send_bits(8'h77, 1'b0, 1'b1, 5, -1, -1);
    repeat (3000) @(posedge clk);
    issue("t5_5a", 8'h5A, 1'b1, 1'b1, -1, -1);

    // 6: reset mid-frame
    $display("frame t6_partial bits=6 then reset");
    send_bits(8'hFF, 1'b1, 1'b1, 6, -1, -1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("t6_reset_dout", {24'h0, bus.dout}, 32'h0);
    check("t6_reset_tick", {31'h0, bus.rx_done_tick}, 32'h0);
    model_dout = 8'h00;
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (20) @(posedge clk);
    issue("t6_c3", 8'hC3, 1'b1, 1'b1, -1, -1);

    // Randomised frames
    for (int k = 0; k < 12; k++) begin
      rd    = 8'($urandom_range(0, 255));
      rpar  = ~(^rd);
      if ($urandom_range(0, 3) == 0) rpar = ~rpar;
      rstop = ($urandom_range(0, 5) != 0);
      bus.rx_en = ($urandom_range(0, 4) != 0);
      drop  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(2, 8)) : -1;
      issue($sformatf("rnd%0d", k), rd, rpar, rstop, -1, drop);
      bus.rx_en = 1'b1;
      repeat (10) @(posedge clk);
    end

    repeat (20) @(posedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
